// File: rtl/mem_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_pkg;

  // Arbiter state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          MEM_AW     = 20;
  localparam int          MEM_DW     = 16;
  localparam logic [15:0] ABORT_DATA = 16'hFFFF;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way picker: fixed priority (m0 wins) or round-robin
// where a tie goes to the master that was not granted last.
module mem_arb_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed,
  output logic       gnt_valid,
  output logic       gnt
);

  // Select the winning master from the current request vector.
  always_comb begin
    gnt_valid = |req;
    gnt       = 1'b0;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11: begin
        if (fixed) begin
          gnt = 1'b0;
        end else begin
          gnt = ~last_grant;
        end
      end
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the CPU (m0) and the VGA/DMA fetcher (m1).
// The grant is held until memory reports ready; a watchdog aborts a
// transaction that never completes and returns ABORT_DATA with an err pulse.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 1023,
  parameter int TW         = 10
) (
  input  logic                cpu_clk,
  input  logic                reset_n,
  input  logic [MEM_AW-1:0]   m0_addr,
  input  logic                m0_byte_m,
  input  logic                m0_op,
  output logic [MEM_DW-1:0]   m0_rd_data,
  output logic                m0_ready,
  input  logic [MEM_AW-1:0]   m1_addr,
  input  logic                m1_byte_m,
  input  logic                m1_op,
  output logic [MEM_DW-1:0]   m1_rd_data,
  output logic                m1_ready,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic                mem_byte_m,
  output logic                mem_op,
  input  logic [MEM_DW-1:0]   mem_rd_data,
  input  logic                mem_ready,
  output logic                err
);

  localparam logic          FIXED   = (FIXED_PRIO != 0) ? 1'b1 : 1'b0;
  localparam logic          WDOG_EN = (TIMEOUT != 0) ? 1'b1 : 1'b0;
  localparam logic [TW-1:0] CNT_MAX = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [TW-1:0] CNT_ONE = TW'(1);

  state_t              state, state_next;
  logic                grant, grant_next;
  logic                last_grant, last_grant_next;
  logic [TW-1:0]       cnt, cnt_next;
  logic [MEM_AW-1:0]   addr_next;
  logic                byte_next;
  logic                op_next;
  logic [MEM_DW-1:0]   rd0_next, rd1_next;
  logic                rdy0_next, rdy1_next;
  logic                err_next;
  logic                gnt_valid;
  logic                gnt;

  mem_arb_pick u_pick (
    .req        ({m1_op, m0_op}),
    .last_grant (last_grant),
    .fixed      (FIXED),
    .gnt_valid  (gnt_valid),
    .gnt        (gnt)
  );

  // State and all registered outputs; last_grant resets to m1 so m0 wins the first tie.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_byte_m <= 1'b0;
      mem_op     <= 1'b0;
      m0_rd_data <= '0;
      m1_rd_data <= '0;
      m0_ready   <= 1'b0;
      m1_ready   <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
      cnt        <= cnt_next;
      mem_addr   <= addr_next;
      mem_byte_m <= byte_next;
      mem_op     <= op_next;
      m0_rd_data <= rd0_next;
      m1_rd_data <= rd1_next;
      m0_ready   <= rdy0_next;
      m1_ready   <= rdy1_next;
      err        <= err_next;
    end
  end

  // Next-state and next-output logic; pulses default low, data holds.
  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    cnt_next        = cnt;
    addr_next       = mem_addr;
    byte_next       = mem_byte_m;
    op_next         = 1'b0;
    rd0_next        = m0_rd_data;
    rd1_next        = m1_rd_data;
    rdy0_next       = 1'b0;
    rdy1_next       = 1'b0;
    err_next        = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          addr_next       = gnt ? m1_addr : m0_addr;
          byte_next       = gnt ? m1_byte_m : m0_byte_m;
          op_next         = 1'b1;
          grant_next      = gnt;
          last_grant_next = gnt;
          cnt_next        = '0;
          state_next      = BUSY;
        end else begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          if (grant) begin
            rd1_next  = mem_rd_data;
            rdy1_next = 1'b1;
          end else begin
            rd0_next  = mem_rd_data;
            rdy0_next = 1'b1;
          end
          state_next = DONE;
        end else if (WDOG_EN && (cnt == CNT_MAX)) begin
          if (grant) begin
            rd1_next  = ABORT_DATA;
            rdy1_next = 1'b1;
          end else begin
            rd0_next  = ABORT_DATA;
            rdy0_next = 1'b1;
          end
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          op_next  = 1'b1;
          cnt_next = cnt + CNT_ONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a round-robin instance (TIMEOUT=8)
// and a fixed-priority instance, checked against a transaction-level model.
module tb_mem_arbiter;

  logic        cpu_clk = 1'b0;
  logic        reset_n;
  logic [19:0] m0_addr, m1_addr;
  logic        m0_byte_m, m1_byte_m, m0_op, m1_op;
  logic [15:0] mem_rd_data;
  logic        mem_ready, f_mem_ready;

  logic [15:0] m0_rd_data, m1_rd_data, f_m0_rd_data, f_m1_rd_data;
  logic        m0_ready, m1_ready, f_m0_ready, f_m1_ready;
  logic [19:0] mem_addr, f_mem_addr;
  logic        mem_byte_m, f_mem_byte_m, mem_op, f_mem_op, err, f_err;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          exp_last;
  logic [15:0] exp_rd0, exp_rd1;

  always #5 cpu_clk = ~cpu_clk;

  mem_arbiter #(.FIXED_PRIO(0), .TIMEOUT(8), .TW(4)) u_rr (
    .cpu_clk(cpu_clk), .reset_n(reset_n),
    .m0_addr(m0_addr), .m0_byte_m(m0_byte_m), .m0_op(m0_op),
    .m0_rd_data(m0_rd_data), .m0_ready(m0_ready),
    .m1_addr(m1_addr), .m1_byte_m(m1_byte_m), .m1_op(m1_op),
    .m1_rd_data(m1_rd_data), .m1_ready(m1_ready),
    .mem_addr(mem_addr), .mem_byte_m(mem_byte_m), .mem_op(mem_op),
    .mem_rd_data(mem_rd_data), .mem_ready(mem_ready), .err(err)
  );

  mem_arbiter #(.FIXED_PRIO(1), .TIMEOUT(8), .TW(4)) u_fx (
    .cpu_clk(cpu_clk), .reset_n(reset_n),
    .m0_addr(m0_addr), .m0_byte_m(m0_byte_m), .m0_op(m0_op),
    .m0_rd_data(f_m0_rd_data), .m0_ready(f_m0_ready),
    .m1_addr(m1_addr), .m1_byte_m(m1_byte_m), .m1_op(m1_op),
    .m1_rd_data(f_m1_rd_data), .m1_ready(f_m1_ready),
    .mem_addr(f_mem_addr), .mem_byte_m(f_mem_byte_m), .mem_op(f_mem_op),
    .mem_rd_data(mem_rd_data), .mem_ready(f_mem_ready), .err(f_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  // Spec-level winner rule: sole requester wins, a tie goes to the
  // master that was not served last (or to m0 under fixed priority).
  function automatic int pick_model(logic r0, logic r1, int last, bit fixed);
    if (r0 && r1) return fixed ? 0 : (1 - last);
    return r0 ? 0 : 1;
  endfunction

  // One transaction on the round-robin instance. lat = BUSY edges with
  // mem_ready low before it rises; abort = mem_ready never comes.
  task automatic txn(input int lat, input bit abort, input bit drop);
    int          w;
    int          nb;
    logic [19:0] ea;
    logic        eb;
    logic [15:0] d;
    w  = pick_model(m0_op, m1_op, exp_last, 1'b0);
    ea = (w == 1) ? m1_addr : m0_addr;
    eb = (w == 1) ? m1_byte_m : m0_byte_m;
    step();
    chk("req_mem_op", 32'(mem_op), 32'd1);
    chk("req_addr", 32'(mem_addr), 32'(ea));
    chk("req_byte", 32'(mem_byte_m), 32'(eb));
    d           = 16'($urandom);
    mem_rd_data = d;
    mem_ready   = (!abort && lat == 0);
    nb          = abort ? 7 : lat;
    for (int k = 0; k < nb; k++) begin
      step();
      chk("busy_mem_op", 32'(mem_op), 32'd1);
      chk("busy_addr", 32'(mem_addr), 32'(ea));
      chk("busy_ready", 32'({m1_ready, m0_ready}), 32'd0);
      chk("busy_err", 32'(err), 32'd0);
      if (!abort && k == nb - 1) mem_ready = 1'b1;
    end
    step();
    exp_last = w;
    if (w == 0) exp_rd0 = abort ? 16'hFFFF : d;
    else        exp_rd1 = abort ? 16'hFFFF : d;
    chk("done_ready", 32'({m1_ready, m0_ready}), (w == 0) ? 32'd1 : 32'd2);
    chk("done_err", 32'(err), 32'(abort));
    chk("done_mem_op", 32'(mem_op), 32'd0);
    chk("done_rd0", 32'(m0_rd_data), 32'(exp_rd0));
    chk("done_rd1", 32'(m1_rd_data), 32'(exp_rd1));
    mem_ready = 1'b0;
    if (drop) begin
      if (w == 0) m0_op = 1'b0;
      else        m1_op = 1'b0;
    end
    step();
    chk("gap_ready", 32'({m1_ready, m0_ready}), 32'd0);
    chk("gap_err", 32'(err), 32'd0);
    chk("gap_mem_op", 32'(mem_op), 32'd0);
    chk("gap_rd0", 32'(m0_rd_data), 32'(exp_rd0));
    chk("gap_rd1", 32'(m1_rd_data), 32'(exp_rd1));
  endtask

  task automatic model_reset();
    exp_last = 1;
    exp_rd0  = 16'h0000;
    exp_rd1  = 16'h0000;
  endtask

  initial begin
    logic [15:0] fd;
    reset_n = 1'b1;
    m0_addr = 20'h00000; m1_addr = 20'h00000;
    m0_byte_m = 1'b0; m1_byte_m = 1'b0; m0_op = 1'b0; m1_op = 1'b0;
    mem_rd_data = 16'h0000; mem_ready = 1'b0; f_mem_ready = 1'b0;
    model_reset();
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mem_op", 32'(mem_op), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
    chk("rst_rd", 32'({m1_rd_data, m0_rd_data}), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_f_all", 32'({f_mem_op, f_m0_ready, f_m1_ready, f_err, f_m0_rd_data}), 32'd0);
    step(); step();
    @(negedge cpu_clk) reset_n = 1'b1;

    // Single m0 read at F0000, mem_ready two BUSY cycles after mem_op.
    m0_addr = 20'hF0000; m0_byte_m = 1'b1; m0_op = 1'b1;
    m1_addr = 20'($urandom);
    txn(2, 1'b0, 1'b1);

    // Random single-master transactions.
    for (int i = 0; i < 4; i++) begin
      m0_addr = 20'($urandom); m1_addr = 20'($urandom);
      m0_byte_m = 1'($urandom); m1_byte_m = 1'($urandom);
      if ($urandom_range(0, 1) == 0) m0_op = 1'b1;
      else                           m1_op = 1'b1;
      txn($urandom_range(0, 4), 1'b0, 1'b1);
    end

    // Both masters requesting continuously: grants alternate.
    m0_op = 1'b1; m1_op = 1'b1;
    for (int i = 0; i < 6; i++) begin
      m0_addr = 20'($urandom);
      m1_addr = m0_addr ^ 20'h80000;
      m0_byte_m = 1'($urandom); m1_byte_m = ~m0_byte_m;
      txn($urandom_range(0, 3), 1'b0, 1'b0);
    end
    m0_op = 1'b0; m1_op = 1'b0;
    step();

    // Watchdog: m1 never completes, then m0 is served normally.
    m1_addr = 20'($urandom); m1_op = 1'b1;
    txn(0, 1'b1, 1'b1);
    m0_addr = 20'($urandom); m0_op = 1'b1;
    txn(1, 1'b0, 1'b1);

    // ROM-style: mem_ready high in the first mem_op cycle; loser stays pending.
    m0_addr = 20'($urandom); m1_addr = m0_addr ^ 20'h40000;
    m0_op = 1'b1; m1_op = 1'b1;
    txn(0, 1'b0, 1'b1);
    txn(0, 1'b0, 1'b1);

    // Fixed priority instance: m0 wins every time, 3-cycle cadence.
    @(negedge cpu_clk) reset_n = 1'b0;
    model_reset();
    step();
    @(negedge cpu_clk) reset_n = 1'b1;
    fd = 16'($urandom);
    mem_rd_data = fd; f_mem_ready = 1'b1;
    m0_addr = 20'($urandom); m1_addr = m0_addr ^ 20'h80000;
    m0_op = 1'b1; m1_op = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      chk("fx_mem_op", 32'(f_mem_op), 32'(k % 3 == 1));
      chk("fx_m0_ready", 32'(f_m0_ready), 32'(k % 3 == 2));
      chk("fx_m1_ready", 32'(f_m1_ready), 32'd0);
      chk("fx_m1_rd", 32'(f_m1_rd_data), 32'd0);
      if (k % 3 == 1) chk("fx_addr", 32'(f_mem_addr), 32'(m0_addr));
      if (k % 3 == 2) chk("fx_m0_rd", 32'(f_m0_rd_data), 32'(fd));
    end
    m0_op = 1'b0; m1_op = 1'b0; f_mem_ready = 1'b0;
    @(negedge cpu_clk) reset_n = 1'b0;
    model_reset();
    step();
    @(negedge cpu_clk) reset_n = 1'b1;
    step();

    // Reset in the middle of BUSY: mem_op drops at once, no ready pulse.
    m0_addr = 20'($urandom); m0_op = 1'b1;
    step();
    chk("pre_rst_mem_op", 32'(mem_op), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_mem_op", 32'(mem_op), 32'd0);
    chk("mid_rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
    model_reset();
    step();
    chk("held_rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
    chk("held_rst_mem_op", 32'(mem_op), 32'd0);
    @(negedge cpu_clk) reset_n = 1'b1;
    m0_addr = 20'($urandom); m1_addr = m0_addr ^ 20'h80000;
    m0_op = 1'b1; m1_op = 1'b1;
    txn(1, 1'b0, 1'b1);
    txn(2, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
